// File: rtl/eth_cmd_rx_if.sv
// Byte-stream receive bus from the RGMII SDR stage plus the decoded command and status outputs.
// The slave modport is the command receiver; the master modport is the PHY/consumer side.
interface eth_cmd_rx_if;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  rx_data;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [23:0] cmd_arg;
  logic        busy;
  logic [15:0] frame_ok_cnt;
  logic [15:0] frame_drop_cnt;

  modport master (
    output rx_dv, rx_er, rx_data,
    input  cmd_valid, cmd_opcode, cmd_arg, busy, frame_ok_cnt, frame_drop_cnt
  );

  modport slave (
    input  rx_dv, rx_er, rx_data,
    output cmd_valid, cmd_opcode, cmd_arg, busy, frame_ok_cnt, frame_drop_cnt
  );
endinterface

// File: rtl/eth_cmd_rx.sv
// Ethernet II / IPv4 / UDP command receiver: turns one accepted frame into one 32-bit command.
// Optional FCS checking is compiled in when the macro ETH_RX_CRC_EN is defined.
module eth_cmd_rx #(
  parameter logic [47:0] LOCAL_MAC = 48'h000A35000102,
  parameter logic [15:0] CMD_PORT  = 16'h1234,
  parameter int          MAX_FRAME = 1522
) (
  input logic         clk,
  input logic         rst,
  eth_cmd_rx_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREAMBLE = 3'd1;
  localparam logic [2:0] S_HEADER   = 3'd2;
  localparam logic [2:0] S_PAYLOAD  = 3'd3;
  localparam logic [2:0] S_TAIL     = 3'd4;
  localparam logic [2:0] S_FILTER   = 3'd5;
  localparam logic [2:0] S_DROP     = 3'd6;

  localparam logic [10:0] CNT_LIMIT = 11'(MAX_FRAME);
  localparam logic [10:0] CNT_MAX   = 11'(MAX_FRAME + 1);

  logic [2:0]  state_q, state_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic        reject_q, reject_d;
  logic        mac_local_q, mac_local_d;
  logic        mac_bcast_q, mac_bcast_d;
  logic        len_hi_zero_q, len_hi_zero_d;
  logic        resync_q, resync_d;
  logic [31:0] hold_q, hold_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [23:0] arg_q, arg_d;
  logic [15:0] ok_cnt_q, ok_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic [7:0]  mac_byte;
  logic        mac_local_now, mac_bcast_now;
  logic        hdr_miss;
  logic [10:0] cnt_inc;
  logic        frame_good, frame_err;
  logic        crc_ok;

  always_comb begin
    mac_byte = 8'h00;
    case (byte_cnt_q[2:0])
      3'd0:    mac_byte = LOCAL_MAC[47:40];
      3'd1:    mac_byte = LOCAL_MAC[39:32];
      3'd2:    mac_byte = LOCAL_MAC[31:24];
      3'd3:    mac_byte = LOCAL_MAC[23:16];
      3'd4:    mac_byte = LOCAL_MAC[15:8];
      3'd5:    mac_byte = LOCAL_MAC[7:0];
      default: mac_byte = 8'h00;
    endcase
    mac_local_now = mac_local_q && (bus.rx_data == mac_byte);
    mac_bcast_now = mac_bcast_q && (bus.rx_data == 8'hFF);

    hdr_miss = 1'b0;
    case (byte_cnt_q)
      11'd5:   hdr_miss = !(mac_local_now || mac_bcast_now);
      11'd12:  hdr_miss = (bus.rx_data != 8'h08);
      11'd13:  hdr_miss = (bus.rx_data != 8'h00);
      11'd14:  hdr_miss = (bus.rx_data != 8'h45);
      11'd23:  hdr_miss = (bus.rx_data != 8'h11);
      11'd36:  hdr_miss = (bus.rx_data != CMD_PORT[15:8]);
      11'd37:  hdr_miss = (bus.rx_data != CMD_PORT[7:0]);
      11'd39:  hdr_miss = len_hi_zero_q && (bus.rx_data < 8'd12);
      default: hdr_miss = 1'b0;
    endcase

    cnt_inc = (byte_cnt_q == CNT_MAX) ? byte_cnt_q : byte_cnt_q + 11'd1;
  end

  // resync_q masks the error count for the tail of a frame that a mid-frame reset cut into.
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    reject_d      = reject_q;
    mac_local_d   = mac_local_q;
    mac_bcast_d   = mac_bcast_q;
    len_hi_zero_d = len_hi_zero_q;
    resync_d      = resync_q && bus.rx_dv;
    hold_d        = hold_q;
    frame_good    = 1'b0;
    frame_err     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_dv) begin
          if (bus.rx_data == 8'h55) begin
            state_d    = S_PREAMBLE;
            byte_cnt_d = 11'd1;
          end else if (bus.rx_data == 8'hD5) begin
            state_d       = S_HEADER;
            byte_cnt_d    = 11'd0;
            reject_d      = 1'b0;
            mac_local_d   = 1'b1;
            mac_bcast_d   = 1'b1;
            len_hi_zero_d = 1'b1;
          end else begin
            state_d   = S_DROP;
            frame_err = !resync_q;
          end
        end
      end

      S_PREAMBLE: begin
        if (!bus.rx_dv) begin
          state_d   = S_IDLE;
          frame_err = 1'b1;
        end else if (bus.rx_er) begin
          state_d   = S_DROP;
          frame_err = 1'b1;
        end else if (bus.rx_data == 8'hD5) begin
          state_d       = S_HEADER;
          byte_cnt_d    = 11'd0;
          reject_d      = 1'b0;
          mac_local_d   = 1'b1;
          mac_bcast_d   = 1'b1;
          len_hi_zero_d = 1'b1;
        end else if ((bus.rx_data == 8'h55) && (byte_cnt_q < 11'd7)) begin
          byte_cnt_d = byte_cnt_q + 11'd1;
        end else begin
          state_d   = S_DROP;
          frame_err = 1'b1;
        end
      end

      S_HEADER: begin
        if (!bus.rx_dv) begin
          state_d   = S_IDLE;
          frame_err = !reject_q;
        end else if (bus.rx_er) begin
          if (reject_q || hdr_miss) begin
            state_d = S_FILTER;
          end else begin
            state_d   = S_DROP;
            frame_err = 1'b1;
          end
        end else begin
          byte_cnt_d = cnt_inc;
          reject_d   = reject_q || hdr_miss;
          if (byte_cnt_q < 11'd6) begin
            mac_local_d = mac_local_now;
            mac_bcast_d = mac_bcast_now;
          end
          if (byte_cnt_q == 11'd38) begin
            len_hi_zero_d = (bus.rx_data == 8'h00);
          end
          if (byte_cnt_q == 11'd41) begin
            state_d = (reject_q || hdr_miss) ? S_FILTER : S_PAYLOAD;
          end
        end
      end

      S_PAYLOAD: begin
        if (!bus.rx_dv) begin
          state_d   = S_IDLE;
          frame_err = 1'b1;
        end else if (bus.rx_er) begin
          state_d   = S_DROP;
          frame_err = 1'b1;
        end else begin
          byte_cnt_d = cnt_inc;
          hold_d     = {hold_q[23:0], bus.rx_data};
          if (byte_cnt_q == 11'd45) begin
            state_d = S_TAIL;
          end
        end
      end

      S_TAIL: begin
        if (!bus.rx_dv) begin
          state_d    = S_IDLE;
          frame_good = crc_ok;
          frame_err  = !crc_ok;
        end else if (bus.rx_er || (byte_cnt_q >= CNT_LIMIT)) begin
          state_d   = S_DROP;
          frame_err = 1'b1;
        end else begin
          byte_cnt_d = cnt_inc;
        end
      end

      S_FILTER, S_DROP: begin
        if (!bus.rx_dv) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid_d = frame_good;
    opcode_d    = frame_good ? hold_q[31:24] : opcode_q;
    arg_d       = frame_good ? hold_q[23:0]  : arg_q;
    ok_cnt_d    = (frame_good && (ok_cnt_q != 16'hFFFF)) ? ok_cnt_q + 16'd1 : ok_cnt_q;
    drop_cnt_d  = (frame_err && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      byte_cnt_q    <= 11'd0;
      reject_q      <= 1'b0;
      mac_local_q   <= 1'b0;
      mac_bcast_q   <= 1'b0;
      len_hi_zero_q <= 1'b0;
      resync_q      <= 1'b1;
      hold_q        <= 32'h0;
      cmd_valid_q   <= 1'b0;
      opcode_q      <= 8'h00;
      arg_q         <= 24'h0;
      ok_cnt_q      <= 16'h0;
      drop_cnt_q    <= 16'h0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      reject_q      <= reject_d;
      mac_local_q   <= mac_local_d;
      mac_bcast_q   <= mac_bcast_d;
      len_hi_zero_q <= len_hi_zero_d;
      resync_q      <= resync_d;
      hold_q        <= hold_d;
      cmd_valid_q   <= cmd_valid_d;
      opcode_q      <= opcode_d;
      arg_q         <= arg_d;
      ok_cnt_q      <= ok_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

`ifdef ETH_RX_CRC_EN
  // Reflected CRC-32; after data plus FCS the bit-reversed register lands on the fixed residue.
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  logic [31:0] crc_q, crc_d, crc_rev;
  logic        crc_start, crc_en;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    crc_start = (state_d == S_HEADER) && (state_q != S_HEADER);
    crc_en    = bus.rx_dv && ((state_q == S_HEADER) || (state_q == S_PAYLOAD) ||
                              (state_q == S_TAIL));
    crc_d     = crc_q;
    if (crc_start) begin
      crc_d = 32'hFFFFFFFF;
    end else if (crc_en) begin
      crc_d = crc_byte(crc_q, bus.rx_data);
    end
    for (int i = 0; i < 32; i++) begin
      crc_rev[i] = crc_q[31-i];
    end
  end

  assign crc_ok = (crc_rev == CRC_RESIDUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= 32'hFFFFFFFF;
    end else begin
      crc_q <= crc_d;
    end
  end
`else
  assign crc_ok = 1'b1;
`endif

  assign bus.cmd_valid      = cmd_valid_q;
  assign bus.cmd_opcode     = opcode_q;
  assign bus.cmd_arg        = arg_q;
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.frame_ok_cnt   = ok_cnt_q;
  assign bus.frame_drop_cnt = drop_cnt_q;

endmodule

// File: doc/eth_cmd_rx.md
# eth_cmd_rx

Receive-side companion to the gigabit Ethernet transmitter. Runs in the 125 MHz Ethernet domain downstream of the RGMII DDR-to-SDR stage. Parses incoming Ethernet II / IPv4 / UDP frames byte by byte and accepts only frames addressed to this board on the command port. Each accepted frame yields one 32-bit command (opcode + argument) that the capture and readout controllers use to start, stop and configure ADC transfers without the MicroBlaze.

## Interface
Parameters:
- LOCAL_MAC, 48'h000A35000102, station MAC; the broadcast address FF:FF:FF:FF:FF:FF is also accepted
- CMD_PORT, 16'h1234, UDP destination port that carries commands
- MAX_FRAME, 1522, largest legal frame length in bytes, counted from the destination MAC through the FCS

Ports:
- clk, in, 1, 125 MHz receive byte clock
- rst, in, 1, asynchronous, active-high reset
- rx_dv, in, 1, receive data valid; high for the whole frame, preamble included
- rx_er, in, 1, PHY receive error
- rx_data, in, 8, receive byte
- cmd_valid, out, 1, one-cycle pulse; a new command is present on cmd_opcode/cmd_arg
- cmd_opcode, out, 8, first payload byte; holds its value until the next cmd_valid
- cmd_arg, out, 24, payload bytes 2..4, big-endian; holds its value until the next cmd_valid
- busy, out, 1, high from the preamble until the frame is resolved
- frame_ok_cnt, out, 16, count of accepted command frames; saturates at FFFF
- frame_drop_cnt, out, 16, count of errored frames; saturates at FFFF

## Operation
- Reset: all outputs 0; FSM goes to IDLE; the CRC register is preset to FFFFFFFF.
- IDLE:
  - rx_dv=1 with rx_data=55 → PREAMBLE.
  - rx_dv=1 with rx_data=D5 → HEADER. A preamble of length 0 is tolerated.
  - rx_dv=1 with any other byte → DROP, counted as an error.
- PREAMBLE:
  - 55 → stay.
  - D5 → HEADER; the byte counter clears to 0.
  - Any other byte, or more than 7 bytes of 55 → DROP, error.
- HEADER: covers byte offsets 0..41 after the SFD. Each check sets a sticky `reject` flag on mismatch; reject is silent and does not count as an error.
  - 0–5: destination MAC must equal LOCAL_MAC or broadcast.
  - 12–13: EtherType must be 0800.
  - 14: must be 45.
  - 23: protocol must be 11.
  - 36–37: UDP destination port must equal CMD_PORT.
  - 38–39: UDP length must be ≥ 12.
  - At offset 41: reject=1 → FILTER, otherwise → PAYLOAD.
- PAYLOAD (offsets 42–45): shift the 4 bytes into a holding register, then → TAIL.
- TAIL: absorb padding and FCS until rx_dv=0.
- FILTER: wait for rx_dv=0, then → IDLE. No counter changes.
- DROP: wait for rx_dv=0, then → IDLE.
- Frame end (rx_dv sampled 0):
  - In TAIL with no error → load cmd_opcode/cmd_arg from the holding register, pulse cmd_valid, increment frame_ok_cnt.
  - In PREAMBLE, HEADER or PAYLOAD → runt frame; increment frame_drop_cnt.
- Errors at any point in the frame:
  - rx_er=1 in any non-IDLE state → DROP, error. Counted once per frame.
  - Byte counter exceeds MAX_FRAME → DROP, error. The byte counter is 11 bits and stops at MAX_FRAME+1.
- A rejected (filtered) frame is never counted as an error, even if rx_er also occurs later in it.

## Timing
- cmd_valid asserts exactly 1 cycle after the first cycle rx_dv is sampled 0 following a good frame. The pulse is 1 cycle wide.
- cmd_opcode/cmd_arg update on the same edge that asserts cmd_valid.
- Counters update on the same edge as cmd_valid, or on the edge after the drop condition is sampled.
- busy:
  - Rises on the edge that leaves IDLE.
  - Falls on the edge that returns to IDLE.
  - Minimum inter-frame gap supported: 1 idle cycle. A new frame may begin on the cycle right after cmd_valid.
- Async rst mid-frame: the FSM returns to IDLE immediately and the partial command is discarded. After release, bytes up to the next rx_dv low are ignored, because a byte with rx_dv=1 that is not 55/D5 drives the FSM to DROP.

## Configuration
- ETH_RX_CRC_EN defined:
  - CRC-32 (polynomial 04C11DB7, reflected, byte-wide) runs over every byte from offset 0 through the last FCS byte.
  - At frame end in TAIL, the register must equal the residue C704DD7B. Otherwise the frame is an error: no cmd_valid, frame_drop_cnt increments.
  - The CRC register is preset to FFFFFFFF when entering HEADER.
- ETH_RX_CRC_EN undefined:
  - No CRC logic is compiled.
  - Every frame that reaches TAIL and ends without rx_er is accepted.

## Test plan
- Good frame: 7×55, D5, LOCAL_MAC, port 1234, payload 01 00 10 00, valid FCS → cmd_valid 1 cycle after rx_dv falls; opcode=01, arg=001000; frame_ok_cnt=1.
- Destination MAC 00:11:22:33:44:55, otherwise valid → no cmd_valid; both counters stay 0; busy falls after rx_dv falls.
- Good frame with rx_er=1 at offset 20 → no cmd_valid; frame_drop_cnt=1. Then a good frame 1 idle cycle later → accepted; frame_ok_cnt=1.
- With ETH_RX_CRC_EN, good frame with the last FCS byte flipped → no cmd_valid; frame_drop_cnt=1. Without the macro, the same frame → accepted.
- rx_dv dropped at offset 30 → frame_drop_cnt=1. Then a 1600-byte frame → frame_drop_cnt=2, with no cmd_valid for either.
- Assert rst at offset 43 of a good frame and release 2 cycles later while rx_dv is still high → no cmd_valid and counters 0. The next good frame → cmd_valid.
